// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute over a shared memory port and ALU.
// Optional MC_PERF_CNT_EN adds the InstrRetired counter output.
module arm_mc_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUControl,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic        IllegalInstr,
`ifdef MC_PERF_CNT_EN
    output logic [31:0] InstrRetired,
`endif
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       s_bit;
    logic       unused_instr_bits;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign rd    = Instr[15:12];
    assign cmd   = funct[4:1];
    assign s_bit = funct[0];
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    logic cond_ex;
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = !flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = !flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = !flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = !flag_v;
            4'b1000: cond_ex = flag_c && !flag_z;
            4'b1001: cond_ex = !flag_c || flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ex = flag_z || (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    logic [1:0] dp_alu_ctl;
    logic       dp_legal;
    logic       is_cmp;
    logic       cmd_arith;
    logic       illegal;
    always_comb begin
        dp_alu_ctl = 2'b00;
        dp_legal   = 1'b1;
        case (cmd)
            4'b0100: dp_alu_ctl = 2'b00;
            4'b0010: dp_alu_ctl = 2'b01;
            4'b0000: dp_alu_ctl = 2'b10;
            4'b1100: dp_alu_ctl = 2'b11;
            4'b1010: dp_alu_ctl = 2'b01;
            default: dp_legal   = 1'b0;
        endcase
    end

    assign is_cmp    = (cmd == 4'b1010);
    assign cmd_arith = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
    assign illegal   = (op == 2'b11) || ((op == 2'b00) && !dp_legal);

    assign ImmSrc    = op;
    assign RegSrc    = {op == 2'b01, op == 2'b10};
    assign state_dbg = state_q;

    always_comb begin
        state_d      = state_q;
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        ResultSrc    = 2'b00;
        ALUControl   = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        RegWrite     = 1'b0;
        IllegalInstr = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = DECODE;
            end
            DECODE: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                IllegalInstr = illegal;
                if (illegal)            state_d = FETCH;
                else if (op == 2'b01)   state_d = MEMADR;
                else if (op == 2'b10)   state_d = BRANCH;
                else if (funct[5])      state_d = EXECUTEI;
                else                    state_d = EXECUTER;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = funct[3] ? 2'b00 : 2'b01;
                state_d    = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex;
                PCWrite   = cond_ex && (rd == 4'd15);
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
                state_d  = FETCH;
            end
            EXECUTER, EXECUTEI: begin
                ALUSrcB    = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
                ALUControl = dp_alu_ctl;
                state_d    = ALUWB;
            end
            ALUWB: begin
                ResultSrc = 2'b00;
                RegWrite  = cond_ex && !is_cmp;
                PCWrite   = cond_ex && (rd == 4'd15);
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // Reset gates every enable and parks the selects on their fetch values.
        if (reset) begin
            PCWrite      = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            RegWrite     = 1'b0;
            IllegalInstr = 1'b0;
            AdrSrc       = 1'b0;
            ALUSrcA      = 1'b1;
            ALUSrcB      = 2'b10;
            ALUControl   = 2'b00;
            ResultSrc    = 2'b10;
        end
    end

    // C and V are only meaningful for the arithmetic commands; logical ops keep them.
    always_comb begin
        flags_d = flags_q;
        if (((state_q == EXECUTER) || (state_q == EXECUTEI)) && (s_bit || is_cmp) && cond_ex) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (cmd_arith) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] instr_retired_q, instr_retired_d;
    always_comb begin
        instr_retired_d = instr_retired_q;
        if ((state_d == FETCH) && (state_q != FETCH)) instr_retired_d = instr_retired_q + 32'd1;
    end
    always_ff @(posedge clk) begin
        if (reset) instr_retired_q <= 32'd0;
        else       instr_retired_q <= instr_retired_d;
    end
    assign InstrRetired = instr_retired_q;
`endif

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: per-cycle state/enable checks over a hand-decoded program.
module tb_arm_mc_controller;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, IllegalInstr;
    logic [1:0]  ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0]  state_dbg;
`ifdef MC_PERF_CNT_EN
    logic [31:0] InstrRetired;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // {PCWrite, IRWrite, MemWrite, RegWrite, IllegalInstr}
    logic [4:0] en_vec;
    assign en_vec = {PCWrite, IRWrite, MemWrite, RegWrite, IllegalInstr};

    arm_mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite), .IllegalInstr(IllegalInstr),
`ifdef MC_PERF_CNT_EN
        .InstrRetired(InstrRetired),
`endif
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Waits to mid-cycle, then checks the current state and the enable vector.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [4:0] en);
        @(negedge clk);
        check_eq({tag, ":state"}, {28'd0, state_dbg}, {28'd0, st});
        check_eq({tag, ":en"}, {27'd0, en_vec}, {27'd0, en});
    endtask

    // Present the next instruction just after the edge that enters FETCH.
    task automatic load(input logic [31:0] i, input logic [3:0] f);
        @(posedge clk);
        #1;
        Instr    = i;
        ALUFlags = f;
    endtask

    initial begin
        reset    = 1'b1;
        Instr    = 32'h0;
        ALUFlags = 4'h0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst:state", {28'd0, state_dbg}, 32'd0);
        check_eq("rst:en", {27'd0, en_vec}, 32'd0);
        check_eq("rst:srcb", {30'd0, ALUSrcB}, 32'd2);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        Instr    = 32'hE2802005;
        ALUFlags = 4'h0;

        // ADD R2,R0,#5
        cyc("add.f", S_FETCH, 5'b11000);
        check_eq("add.f:adrsrc", {31'd0, AdrSrc}, 32'd0);
        check_eq("add.f:srca", {31'd0, ALUSrcA}, 32'd1);
        check_eq("add.f:srcb", {30'd0, ALUSrcB}, 32'd2);
        check_eq("add.f:res", {30'd0, ResultSrc}, 32'd2);
        check_eq("add.f:alu", {30'd0, ALUControl}, 32'd0);
        cyc("add.d", S_DECODE, 5'b00000);
        check_eq("add.d:immsrc", {30'd0, ImmSrc}, 32'd0);
        check_eq("add.d:regsrc", {30'd0, RegSrc}, 32'd0);
        cyc("add.e", S_EXECI, 5'b00000);
        check_eq("add.e:srcb", {30'd0, ALUSrcB}, 32'd1);
        check_eq("add.e:alu", {30'd0, ALUControl}, 32'd0);
        cyc("add.w", S_ALUWB, 5'b00010);
        check_eq("add.w:res", {30'd0, ResultSrc}, 32'd0);

        // STR R2,[R0,#100]
        load(32'hE5802064, 4'h0);
        cyc("str.f", S_FETCH, 5'b11000);
        cyc("str.d", S_DECODE, 5'b00000);
        cyc("str.a", S_MEMADR, 5'b00000);
        check_eq("str.a:alu", {30'd0, ALUControl}, 32'd0);
        check_eq("str.a:srcb", {30'd0, ALUSrcB}, 32'd1);
        cyc("str.m", S_MEMWRITE, 5'b00100);
        check_eq("str.m:adrsrc", {31'd0, AdrSrc}, 32'd1);

        // LDR R2,[R0,#96]
        load(32'hE5902060, 4'h0);
        cyc("ldr.f", S_FETCH, 5'b11000);
        cyc("ldr.d", S_DECODE, 5'b00000);
        check_eq("ldr.d:immsrc", {30'd0, ImmSrc}, 32'd1);
        check_eq("ldr.d:regsrc", {30'd0, RegSrc}, 32'd2);
        cyc("ldr.a", S_MEMADR, 5'b00000);
        cyc("ldr.r", S_MEMREAD, 5'b00000);
        check_eq("ldr.r:adrsrc", {31'd0, AdrSrc}, 32'd1);
        cyc("ldr.w", S_MEMWB, 5'b00010);
        check_eq("ldr.w:res", {30'd0, ResultSrc}, 32'd1);

        // CMP R2,R3 with Z from the ALU
        load(32'hE1520003, 4'b0100);
        cyc("cmp.f", S_FETCH, 5'b11000);
        cyc("cmp.d", S_DECODE, 5'b00000);
        cyc("cmp.e", S_EXECR, 5'b00000);
        check_eq("cmp.e:srcb", {30'd0, ALUSrcB}, 32'd0);
        check_eq("cmp.e:alu", {30'd0, ALUControl}, 32'd1);
        cyc("cmp.w", S_ALUWB, 5'b00000);

        // BEQ taken, BNE not taken
        load(32'h0A000002, 4'h0);
        cyc("beq.f", S_FETCH, 5'b11000);
        cyc("beq.d", S_DECODE, 5'b00000);
        check_eq("beq.d:regsrc", {30'd0, RegSrc}, 32'd1);
        cyc("beq.b", S_BRANCH, 5'b10000);
        check_eq("beq.b:srcb", {30'd0, ALUSrcB}, 32'd1);
        check_eq("beq.b:res", {30'd0, ResultSrc}, 32'd2);
        check_eq("beq.b:alu", {30'd0, ALUControl}, 32'd0);
        load(32'h1A000002, 4'h0);
        cyc("bne.f", S_FETCH, 5'b11000);
        cyc("bne.d", S_DECODE, 5'b00000);
        cyc("bne.b", S_BRANCH, 5'b00000);

        // ADDS R0,R0,#0 with C=1 -> flags 0010
        load(32'hE2900000, 4'b0010);
        cyc("adds.f", S_FETCH, 5'b11000);
        cyc("adds.d", S_DECODE, 5'b00000);
        cyc("adds.e", S_EXECI, 5'b00000);
        cyc("adds.w", S_ALUWB, 5'b00010);

        // ADDEQ with Z=0: condition fails, flags untouched
        load(32'h02800000, 4'b0100);
        cyc("addeq.f", S_FETCH, 5'b11000);
        cyc("addeq.d", S_DECODE, 5'b00000);
        cyc("addeq.e", S_EXECI, 5'b00000);
        cyc("addeq.w", S_ALUWB, 5'b00000);
        load(32'h0A000002, 4'h0);
        cyc("beq2.f", S_FETCH, 5'b11000);
        cyc("beq2.d", S_DECODE, 5'b00000);
        cyc("beq2.b", S_BRANCH, 5'b00000);

        // ORRS with ALU NZCV=0100: Z set, C stays 1
        load(32'hE3900000, 4'b0100);
        cyc("orrs.f", S_FETCH, 5'b11000);
        cyc("orrs.d", S_DECODE, 5'b00000);
        cyc("orrs.e", S_EXECI, 5'b00000);
        check_eq("orrs.e:alu", {30'd0, ALUControl}, 32'd3);
        cyc("orrs.w", S_ALUWB, 5'b00010);
        load(32'h2A000002, 4'h0);
        cyc("bcs.f", S_FETCH, 5'b11000);
        cyc("bcs.d", S_DECODE, 5'b00000);
        cyc("bcs.b", S_BRANCH, 5'b10000);
        load(32'h0A000002, 4'h0);
        cyc("beq3.f", S_FETCH, 5'b11000);
        cyc("beq3.d", S_DECODE, 5'b00000);
        cyc("beq3.b", S_BRANCH, 5'b10000);

        // Cond=1111 never executes
        load(32'hF2802005, 4'h0);
        cyc("nv.f", S_FETCH, 5'b11000);
        cyc("nv.d", S_DECODE, 5'b00000);
        cyc("nv.e", S_EXECI, 5'b00000);
        cyc("nv.w", S_ALUWB, 5'b00000);

        // ADD PC,R0,#4: Rd=15 also writes the PC
        load(32'hE280F004, 4'h0);
        cyc("addpc.f", S_FETCH, 5'b11000);
        cyc("addpc.d", S_DECODE, 5'b00000);
        cyc("addpc.e", S_EXECI, 5'b00000);
        cyc("addpc.w", S_ALUWB, 5'b10010);

        // Op=11 and an unsupported cmd (EOR) are both illegal
        load(32'hEC000000, 4'h0);
        cyc("ill.f", S_FETCH, 5'b11000);
        cyc("ill.d", S_DECODE, 5'b00001);
        load(32'hE0200000, 4'h0);
        cyc("eor.f", S_FETCH, 5'b11000);
        cyc("eor.d", S_DECODE, 5'b00001);
        cyc("eor.n", S_FETCH, 5'b11000);

        // Reset during MEMWRITE
        Instr = 32'hE5802064;
        cyc("rstr.d", S_DECODE, 5'b00000);
        cyc("rstr.a", S_MEMADR, 5'b00000);
        cyc("rstr.m", S_MEMWRITE, 5'b00100);
        reset = 1'b1;
        #1;
        check_eq("rstr.m:en", {27'd0, en_vec}, 32'd0);
        check_eq("rstr.m:srca", {31'd0, ALUSrcA}, 32'd1);
        check_eq("rstr.m:adrsrc", {31'd0, AdrSrc}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("rstr:state", {28'd0, state_dbg}, {28'd0, S_FETCH});
`ifdef MC_PERF_CNT_EN
        check_eq("rstr:retired", InstrRetired, 32'd0);
`endif
        reset    = 1'b0;
        Instr    = 32'h2A000002;
        ALUFlags = 4'h0;
        // Flags cleared by reset, so BCS falls through
        cyc("bcs2.f", S_FETCH, 5'b11000);
        cyc("bcs2.d", S_DECODE, 5'b00000);
        cyc("bcs2.b", S_BRANCH, 5'b00000);
        @(posedge clk);
        #1;
        check_eq("bcs2:next", {28'd0, state_dbg}, {28'd0, S_FETCH});
`ifdef MC_PERF_CNT_EN
        check_eq("bcs2:retired", InstrRetired, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
